keystream_gen: RTL and testbench
================================

KEYSTREAM_GEN -- requirements
Module: keystream_gen

Interface
REQ-001 The block SHALL have parameter POLY, default 16'hB400, the Galois LFSR feedback mask.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-004 The block SHALL have port load_seed, input, 1 bit, a one-cycle request to load seed.
REQ-005 The block SHALL have port seed, input, 16 bits, the LFSR seed, sampled when load_seed=1.
REQ-006 The block SHALL have port key_ready, input, 1 bit; the consumer accepts key when it and key_valid are both 1.
REQ-007 The block SHALL have port key_valid, output, 1 bit, meaning key holds a completed keystream byte.
REQ-008 The block SHALL have port key, output, 8 bits, the keystream byte that drives the xor_cipher key port.
REQ-009 The block SHALL have port busy, output, 1 bit, equal to 1 in state GEN.
REQ-010 The block SHALL have port seed_err, output, 1 bit, a sticky flag set when a zero seed is requested.
REQ-011 The block SHALL have port key_count, output, 16 bits, the number of accepted bytes.

Function
REQ-012 The block SHALL use a state machine with states IDLE, GEN and HOLD.
REQ-013 The block SHALL hold a 16-bit LFSR s, a 3-bit shift counter cnt and an 8-bit shift register ksr.
REQ-014 Each GEN cycle SHALL apply: lsb=s[0]; s<=(s>>1)^(lsb?POLY:0); ksr<={lsb,ksr[7:1]}; cnt<=cnt+1.
REQ-015 The first bit shifted out SHALL land in key[0] (bytes are LSB-first).
REQ-016 When load_seed=1 and seed!=0, in any state, the block SHALL set s<=seed, cnt<=0, key_valid<=0, go to GEN and clear seed_err.
REQ-017 When load_seed=1 and seed==0, the block SHALL set seed_err<=1, go to IDLE, set key_valid<=0 and leave s unchanged.
REQ-018 In GEN with cnt==7, the shift on that edge SHALL complete the byte: key<=final ksr value, key_valid<=1, go to HOLD.
REQ-019 Latency: if load_seed is sampled at edge 0, shifts SHALL occur at edges 1..8 and key_valid SHALL be 1 after edge 8.
REQ-020 In HOLD, key and key_valid SHALL stay stable until the handshake, with no timeout.
REQ-021 A handshake at edge k SHALL set key_valid<=0, increment key_count (wrapping FFFF->0000) and go to GEN; the next byte SHALL be valid after edge k+8.
REQ-022 key_ready outside HOLD SHALL have no effect.
REQ-023 load_seed in GEN SHALL restart the byte; ksr contents are discarded.
REQ-024 load_seed in HOLD SHALL drop the pending byte without counting it; load_seed takes priority over a simultaneous handshake.
REQ-025 The block SHALL stay in IDLE, with no shifting, until a valid load_seed.
REQ-026 key_count SHALL never clear except on reset.

Reset
REQ-027 While reset=1, asynchronously: state=IDLE, s=0, cnt=0, ksr=0, key=8'h00, key_valid=0, busy=0, seed_err=0, key_count=0.
REQ-028 After reset deasserts, the block SHALL stay in IDLE until load_seed; reset mid-GEN or mid-HOLD SHALL abandon the byte immediately.

Verification
REQ-029 Bench SHALL cover: seed=16'h0001, key_ready=1 -> key=8'h01 valid after edge 8; next key=8'h68; s=16'h7C41 after 16 shifts; key_count=2.
REQ-030 Bench SHALL cover: seed=16'h0001, key_ready=0 for 20 cycles -> key holds 8'h01, key_valid=1, key_count=0; key_ready=1 -> one handshake, key_count=1.
REQ-031 Bench SHALL cover: seed=16'h0000 -> seed_err=1, state IDLE, key_valid stays 0; then seed=16'h0001 -> seed_err=0, key=8'h01.
REQ-032 Bench SHALL cover: load_seed(16'h0001) asserted mid-GEN at cnt=4 -> restart; key=8'h01 valid 8 edges after the reload.
REQ-033 Bench SHALL cover: load_seed and handshake in the same HOLD cycle -> key_count unchanged, new byte generated from the new seed.
REQ-034 Bench SHALL cover: reset pulse mid-HOLD -> all outputs 0 immediately, asynchronously; key fed through two chained xor_cipher instances returns the plaintext unchanged.

Source files
------------

// File: rtl/keystream_gen.sv
// keystream_gen: Galois-LFSR keystream byte generator with a valid/ready output handshake
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   load_seed  one-cycle request to load seed (zero seed is rejected and flagged)
//   seed       16-bit LFSR seed, sampled with load_seed
//   key_ready  consumer accepts key when key_ready and key_valid are both high
//   key_valid  key holds a completed keystream byte
//   key        keystream byte, LSB-first (first bit shifted out lands in key[0])
//   busy       high while a byte is being generated
//   seed_err   sticky flag, set by a zero-seed request, cleared by a valid seed
//   key_count  number of accepted bytes, wraps, cleared only by reset
module keystream_gen #(
  parameter logic [15:0] POLY = 16'hB400
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_seed,
  input  logic [15:0] seed,
  input  logic        key_ready,
  output logic        key_valid,
  output logic [7:0]  key,
  output logic        busy,
  output logic        seed_err,
  output logic [15:0] key_count
);
  typedef enum logic [1:0] {IDLE, GEN, HOLD} state_t;
  state_t      state_q, state_d;
  logic [15:0] s_q, s_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  ksr_q, ksr_d;
  logic [7:0]  key_q, key_d;
  logic        key_valid_q, key_valid_d;
  logic        seed_err_q, seed_err_d;
  logic [15:0] key_count_q, key_count_d;
  logic        lsb;
  logic [15:0] s_next;
  logic [7:0]  ksr_next;
  assign lsb      = s_q[0];
  assign s_next   = (s_q >> 1) ^ (lsb ? POLY : 16'h0000);
  assign ksr_next = {lsb, ksr_q[7:1]};
  // load_seed outranks every state action, including a handshake in HOLD
  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    cnt_d       = cnt_q;
    ksr_d       = ksr_q;
    key_d       = key_q;
    key_valid_d = key_valid_q;
    seed_err_d  = seed_err_q;
    key_count_d = key_count_q;
    if (load_seed) begin
      key_valid_d = 1'b0;
      if (seed != 16'h0000) begin
        s_d        = seed;
        cnt_d      = 3'd0;
        state_d    = GEN;
        seed_err_d = 1'b0;
      end else begin
        seed_err_d = 1'b1;
        state_d    = IDLE;
      end
    end else begin
      case (state_q)
        GEN: begin
          s_d   = s_next;
          ksr_d = ksr_next;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            key_d       = ksr_next;
            key_valid_d = 1'b1;
            state_d     = HOLD;
          end
        end
        HOLD: begin
          if (key_ready) begin
            key_valid_d = 1'b0;
            key_count_d = key_count_q + 16'd1;
            state_d     = GEN;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      s_q         <= 16'h0000;
      cnt_q       <= 3'd0;
      ksr_q       <= 8'h00;
      key_q       <= 8'h00;
      key_valid_q <= 1'b0;
      seed_err_q  <= 1'b0;
      key_count_q <= 16'h0000;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      cnt_q       <= cnt_d;
      ksr_q       <= ksr_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
      seed_err_q  <= seed_err_d;
      key_count_q <= key_count_d;
    end
  end
  assign key_valid = key_valid_q;
  assign key       = key_q;
  assign busy      = (state_q == GEN);
  assign seed_err  = seed_err_q;
  assign key_count = key_count_q;
endmodule

// File: tb/tb_keystream_gen.sv
// tb_keystream_gen: directed scoreboard bench for keystream_gen
module tb_keystream_gen;
  logic        clk = 1'b0;
  logic        reset;
  logic        load_seed;
  logic [15:0] seed;
  logic        key_ready;
  logic        key_valid;
  logic [7:0]  key;
  logic        busy;
  logic        seed_err;
  logic [15:0] key_count;
  logic [7:0]  pt, ct, rt;
  logic [7:0]  sb[$];
  int          total = 0;
  int          bad = 0;
  int          exp_count = 0;
  keystream_gen dut (
    .clk(clk), .reset(reset), .load_seed(load_seed), .seed(seed), .key_ready(key_ready),
    .key_valid(key_valid), .key(key), .busy(busy), .seed_err(seed_err), .key_count(key_count)
  );
  // two chained xor_cipher stages: encrypt then decrypt with the same key
  assign ct = pt ^ key;
  assign rt = ct ^ key;
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic load(input logic [15:0] v);
    load_seed = 1'b1;
    seed = v;
    tick();
    load_seed = 1'b0;
  endtask
  // called right after the edge that entered GEN: 7 more edges still invalid, the 8th completes the byte
  task automatic expect_byte(input string tag);
    logic [7:0] e;
    repeat (7) tick();
    chk({tag, "_notyet"}, key_valid, 1'b0);
    tick();
    chk({tag, "_valid"}, key_valid, 1'b1);
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_key"}, key, e);
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    reset = 1'b1;
    load_seed = 1'b0;
    seed = 16'h0000;
    key_ready = 1'b0;
    pt = 8'h00;
    #3;
    chk("rst_key", key, 8'h00);
    chk("rst_valid", key_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", seed_err, 1'b0);
    chk("rst_count", key_count, 16'h0000);
    repeat (2) tick();
    reset = 1'b0;
    repeat (3) tick();
    chk("idle_busy", busy, 1'b0);
    chk("idle_s", dut.s_q, 16'h0000);
    // seed 1, consumer always ready: 0x01 then 0x68, LFSR at 7C41 after 16 shifts
    key_ready = 1'b1;
    sb.push_back(8'h01);
    sb.push_back(8'h68);
    load(16'h0001);
    chk("t1_busy", busy, 1'b1);
    expect_byte("t1_b0");
    tick();
    exp_count++;
    chk("t1_hs1_valid", key_valid, 1'b0);
    chk("t1_hs1_count", key_count, exp_count);
    expect_byte("t1_b1");
    chk("t1_s", dut.s_q, 16'h7C41);
    tick();
    exp_count++;
    chk("t1_count2", key_count, 16'd2);
    key_ready = 1'b0;
    // consumer stalls for 20 cycles, byte must hold
    sb.push_back(8'h01);
    load(16'h0001);
    expect_byte("t2_b0");
    repeat (20) tick();
    chk("t2_hold_key", key, 8'h01);
    chk("t2_hold_valid", key_valid, 1'b1);
    chk("t2_hold_count", key_count, exp_count);
    chk("t2_hold_busy", busy, 1'b0);
    key_ready = 1'b1;
    tick();
    key_ready = 1'b0;
    exp_count++;
    chk("t2_hs_count", key_count, exp_count);
    chk("t2_hs_valid", key_valid, 1'b0);
    repeat (10) tick();
    chk("t2_next_key", key, 8'h68);
    chk("t2_one_hs", key_count, exp_count);
    // zero seed rejected, LFSR untouched
    load(16'h0000);
    chk("t3_err", seed_err, 1'b1);
    chk("t3_state", dut.state_q, 2'd0);
    chk("t3_valid", key_valid, 1'b0);
    repeat (10) tick();
    chk("t3_stay_valid", key_valid, 1'b0);
    chk("t3_stay_busy", busy, 1'b0);
    chk("t3_s", dut.s_q, 16'h7C41);
    chk("t3_sticky", seed_err, 1'b1);
    sb.push_back(8'h01);
    load(16'h0001);
    chk("t3_err_clr", seed_err, 1'b0);
    expect_byte("t3_b0");
    // reload mid-GEN at cnt=4 restarts the byte
    load(16'h0001);
    repeat (4) tick();
    chk("t4_cnt", dut.cnt_q, 3'd4);
    sb.push_back(8'h01);
    load(16'h0001);
    chk("t4_cnt0", dut.cnt_q, 3'd0);
    expect_byte("t4_b0");
    chk("t4_count", key_count, exp_count);
    // reload and handshake together in HOLD: reload wins, nothing counted
    key_ready = 1'b1;
    sb.push_back(8'h68);
    load(16'h0168);
    key_ready = 1'b0;
    chk("t5_count", key_count, exp_count);
    chk("t5_valid", key_valid, 1'b0);
    expect_byte("t5_b0");
    // xor round trip with the live key, then asynchronous reset mid-HOLD
    sb.push_back(8'h01);
    load(16'h0001);
    expect_byte("t6_b0");
    for (int i = 0; i < 3; i++) begin
      pt = 8'h3C + 8'(i * 8'h5A);
      #1;
      chk("t6_ct", ct, pt ^ 8'h01);
      chk("t6_rt", rt, pt);
    end
    #2;
    reset = 1'b1;
    #1;
    chk("t6_arst_key", key, 8'h00);
    chk("t6_arst_valid", key_valid, 1'b0);
    chk("t6_arst_busy", busy, 1'b0);
    chk("t6_arst_count", key_count, 16'h0000);
    chk("t6_arst_err", seed_err, 1'b0);
    #1;
    reset = 1'b0;
    repeat (3) tick();
    chk("t6_post_busy", busy, 1'b0);
    chk("t6_post_valid", key_valid, 1'b0);
    chk("t6_sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
